weight_pingpong_buffer: RTL and testbench

WEIGHT_PINGPONG_BUFFER -- requirements
Module: weight_pingpong_buffer

---
 rtl/weight_pingpong_buffer.sv | 171 +++++++++++++++++
 tb/tb_weight_pingpong_buffer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/weight_pingpong_buffer.sv
// Double-buffered SIZE x SIZE weight store: one bank fills while the other streams a row per cycle.
// Optional per-entry even parity is enabled with `define WEIGHT_BUF_PARITY_EN.
module weight_pingpong_buffer #(
    parameter int SIZE       = 8,
    parameter int DATA_WIDTH = 5,
    parameter int ADDR_WIDTH = $clog2(SIZE*SIZE)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          load_done,
    output logic                          wr_ready,
    input  logic                          rd_start,
    output logic                          rd_ready,
    output logic                          rd_valid,
    output logic [(SIZE > 1 ? $clog2(SIZE) : 1)-1:0] rd_row,
    output logic [SIZE*DATA_WIDTH-1:0]    rd_data,
`ifdef WEIGHT_BUF_PARITY_EN
    input  logic                          wr_par_flip,
    output logic                          parity_err,
`endif
    output logic                          rd_last
);
    localparam int DEPTH = SIZE * SIZE;
    localparam int RW    = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic {IDLE, STREAM} state_t;

    logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];
    logic [1:0]            full_q, full_d;
    logic                  wb_q, wb_d, rb_q, rb_d;
    state_t                state_q, state_d;
    logic [RW-1:0]         cnt_q, cnt_d;
    logic                  vld_q, vld_d, last_q, last_d;
    logic [RW-1:0]         row_q, row_d;
    logic [SIZE*DATA_WIDTH-1:0] data_q, data_d, row_vec;

    logic                  load, src_bank, last_cyc, start_ok, wr_ok, row_bad;
    logic [RW-1:0]         src_row;
    logic [ADDR_WIDTH-1:0] el_idx;

    assign wr_ready = !full_q[wb_q];
    assign rd_ready = (state_q == IDLE) && full_q[rb_q];
    assign rd_valid = vld_q;
    assign rd_row   = row_q;
    assign rd_last  = last_q;
    assign rd_data  = data_q;

    assign wr_ok    = wr_en && wr_ready && ({1'b0, wr_addr} < DEPTH_W);
    assign last_cyc = (state_q == STREAM) && (cnt_q == RW'(SIZE-1));
    // A start on the final row chains straight into the other bank when it is already full.
    assign start_ok = rd_start && (rd_ready || (last_cyc && full_q[~rb_q]));

`ifdef WEIGHT_BUF_PARITY_EN
    logic par_q [2][DEPTH];
    logic perr_q;
    assign parity_err = perr_q;
`endif

    always_comb begin
        row_vec = '0;
        row_bad = 1'b0;
        el_idx  = '0;
        for (int j = 0; j < SIZE; j++) begin
            el_idx = ADDR_WIDTH'(int'(src_row) * SIZE + j);
            row_vec[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[src_bank][el_idx];
`ifdef WEIGHT_BUF_PARITY_EN
            row_bad = row_bad | ((^mem_q[src_bank][el_idx]) ^ par_q[src_bank][el_idx]);
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wb_d     = wb_q;
        rb_d     = rb_q;
        full_d   = full_q;
        vld_d    = 1'b0;
        row_d    = '0;
        last_d   = 1'b0;
        data_d   = data_q;
        load     = 1'b0;
        src_bank = rb_q;
        src_row  = '0;
        if (load_done && wr_ready) begin
            full_d[wb_q] = 1'b1;
            wb_d         = ~wb_q;
        end
        case (state_q)
            IDLE: if (start_ok) begin
                load    = 1'b1;
                state_d = STREAM;
            end
            STREAM: if (last_cyc) begin
                full_d[rb_q] = 1'b0;
                rb_d         = ~rb_q;
                state_d      = IDLE;
                if (start_ok) begin
                    load     = 1'b1;
                    src_bank = ~rb_q;
                    state_d  = STREAM;
                end
            end else begin
                load    = 1'b1;
                src_row = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            cnt_d  = src_row;
            vld_d  = 1'b1;
            row_d  = src_row;
            last_d = (src_row == RW'(SIZE-1));
            data_d = row_vec;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wb_q    <= 1'b0;
            rb_q    <= 1'b0;
            full_q  <= '0;
            vld_q   <= 1'b0;
            row_q   <= '0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wb_q    <= wb_d;
            rb_q    <= rb_d;
            full_q  <= full_d;
            vld_q   <= vld_d;
            row_q   <= row_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < DEPTH; i++)
                    mem_q[b][i] <= '0;
        end else if (wr_ok) begin
            mem_q[wb_q][wr_addr] <= wr_data;
        end
    end

`ifdef WEIGHT_BUF_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < DEPTH; i++)
                    par_q[b][i] <= 1'b0;
        end else begin
            perr_q <= perr_q | (load & row_bad);
            if (wr_ok)
                par_q[wb_q][wr_addr] <= (^wr_data) ^ wr_par_flip;
        end
    end
`endif

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Scoreboard bench for weight_pingpong_buffer (SIZE=8, DATA_WIDTH=5); parity case runs with WEIGHT_BUF_PARITY_EN.
module tb_weight_pingpong_buffer;
    localparam int SIZE = 8;
    localparam int DW   = 5;
    localparam int AW   = 6;

    typedef struct {
        logic [2:0]         row;
        logic [SIZE*DW-1:0] data;
        logic               last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [DW-1:0]     wr_data = '0;
    logic              load_done = 1'b0;
    logic              wr_ready;
    logic              rd_start = 1'b0;
    logic              rd_ready;
    logic              rd_valid;
    logic [2:0]        rd_row;
    logic [SIZE*DW-1:0] rd_data;
    logic              rd_last;
`ifdef WEIGHT_BUF_PARITY_EN
    logic              wr_par_flip = 1'b0;
    logic              parity_err;
`endif

    weight_pingpong_buffer #(.SIZE(SIZE), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .load_done(load_done), .wr_ready(wr_ready), .rd_start(rd_start), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_row(rd_row), .rd_data(rd_data),
`ifdef WEIGHT_BUF_PARITY_EN
        .wr_par_flip(wr_par_flip), .parity_err(parity_err),
`endif
        .rd_last(rd_last)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    logic [DW-1:0] mdl [2][SIZE*SIZE];
    logic [1:0]    mfull;
    logic          mwb, mrb;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < SIZE*SIZE; i++)
                mdl[b][i] = '0;
        mfull = '0;
        mwb   = 1'b0;
        mrb   = 1'b0;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input logic ld);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; load_done = ld;
        if (!mfull[mwb]) begin
            mdl[mwb][a] = d;
            if (ld) begin mfull[mwb] = 1'b1; mwb = ~mwb; end
        end
        @(negedge clk);
        wr_en = 1'b0; load_done = 1'b0;
    endtask

    task automatic ld_pulse();
        load_done = 1'b1;
        if (!mfull[mwb]) begin mfull[mwb] = 1'b1; mwb = ~mwb; end
        @(negedge clk);
        load_done = 1'b0;
    endtask

    // pattern k: value = (a*mul + add) % 32
    task automatic fill(input int mul, input int add);
        for (int a = 0; a < SIZE*SIZE; a++)
            wr(a, DW'((a*mul + add) % 32), 1'b0);
    endtask

    task automatic push_bank();
        exp_t e;
        for (int r = 0; r < SIZE; r++) begin
            e.row  = 3'(r);
            e.last = (r == SIZE-1);
            for (int j = 0; j < SIZE; j++)
                e.data[j*DW +: DW] = mdl[mrb][r*SIZE + j];
            sb_q.push_back(e);
        end
        mfull[mrb] = 1'b0;
        mrb = ~mrb;
    endtask

    // Streams nb banks back to back with rd_start held; checks gap-free valid and idle after.
    task automatic stream(input int nb, input string tag);
        for (int b = 0; b < nb; b++) push_bank();
        rd_start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < SIZE*nb; i++) begin
            check({tag, "_vld"}, 64'(rd_valid), 64'd1);
            @(negedge clk);
            if (i == SIZE*nb - 2) rd_start = 1'b0;
        end
        rd_start = 1'b0;
        check({tag, "_vld_end"}, 64'(rd_valid), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rd_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_row", 64'(rd_row), 64'hFFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("row_idx", 64'(rd_row), 64'(e.row));
                check("row_data", 64'(rd_data), 64'(e.data));
                check("row_last", 64'(rd_last), 64'(e.last));
            end
        end else if (rst_n) begin
            check("idle_row", 64'({rd_row, rd_last}), 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mdl_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_wr_ready", 64'(wr_ready), 64'd1);
        check("rst_rd_ready", 64'(rd_ready), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_data",  64'(rd_data),  64'd0);

        // Fill bank0 with addr[4:0], stream it
        fill(1, 0);
        ld_pulse();
        check("ready_after_load", 64'(rd_ready), 64'd1);
        stream(1, "b0");

        // rd_start with nothing full is ignored
        rd_start = 1'b1; @(negedge clk); rd_start = 1'b0;
        check("ignored_start", 64'(rd_valid), 64'd0);

        // Fill both banks; further writes and load_done ignored
        fill(3, 1);
        ld_pulse();
        fill(5, 7);
        ld_pulse();
        check("both_full_wr_ready", 64'(wr_ready), 64'd0);
        wr(5, 5'd31, 1'b0);
        wr(9, 5'd30, 1'b1);
        check("still_full", 64'(wr_ready), 64'd0);
        check("rd_ready_full", 64'(rd_ready), 64'd1);

        // Back-to-back stream of both banks
        stream(2, "b2b");
        check("b2b_wr_ready", 64'(wr_ready), 64'd1);
        check("b2b_rd_ready", 64'(rd_ready), 64'd0);

        // Reset during row 3 of a stream
        fill(7, 3);
        ld_pulse();
        push_bank();
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        repeat (3) @(negedge clk);
        check("row3_shown", 64'(rd_row), 64'd3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_rd_valid", 64'(rd_valid), 64'd0);
        check("abort_wr_ready", 64'(wr_ready), 64'd1);
        check("abort_rd_ready", 64'(rd_ready), 64'd0);
        sb_q.delete();
        mdl_reset();
        fill(11, 2);
        ld_pulse();
        stream(1, "post_rst");

        // Write with load_done on address 63 lands before the bank is closed
        for (int a = 0; a < SIZE*SIZE-1; a++) wr(a, DW'(a % 32), 1'b0);
        wr(63, 5'd21, 1'b1);
        check("a63_rd_ready", 64'(rd_ready), 64'd1);
        stream(1, "a63");

`ifdef WEIGHT_BUF_PARITY_EN
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        mdl_reset();
        for (int a = 0; a < SIZE*SIZE; a++) begin
            wr_par_flip = (a == 10);
            wr(a, DW'(a % 32), 1'b0);
        end
        wr_par_flip = 1'b0;
        ld_pulse();
        push_bank();
        rd_start = 1'b1; @(negedge clk); rd_start = 1'b0;
        check("par_row0", 64'(parity_err), 64'd0);
        @(negedge clk);
        check("par_row1", 64'(parity_err), 64'd1);
        repeat (8) @(negedge clk);
        check("par_sticky", 64'(parity_err), 64'd1);
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        check("par_cleared", 64'(parity_err), 64'd0);
`endif

        repeat (2) @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
